// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle command front end for the combinational 32-bit ALU.
// Screens commands for illegal opcodes and zero divisors, registers legal
// operands onto the ALU inputs, captures the ALU result and returns it over a
// held valid/ready response, while counting good and rejected responses.
module alu_sequencer #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned OPCODE_WIDTH    = 6,
    parameter int unsigned OP_COUNT_WIDTH  = 16,
    parameter int unsigned ERR_COUNT_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmdValid,
    output logic                       cmdReady,
    input  logic [OPCODE_WIDTH-1:0]    cmdOpCode,
    input  logic [DATA_WIDTH-1:0]      cmdData1,
    input  logic [DATA_WIDTH-1:0]      cmdData2,
    output logic [OPCODE_WIDTH-1:0]    aluOpCode,
    output logic [DATA_WIDTH-1:0]      aluInputData1,
    output logic [DATA_WIDTH-1:0]      aluInputData2,
    input  logic [DATA_WIDTH-1:0]      aluOutputData,
    output logic                       rspValid,
    input  logic                       rspReady,
    output logic [DATA_WIDTH-1:0]      rspData,
    output logic                       rspError,
    output logic [OP_COUNT_WIDTH-1:0]  opCount,
    output logic [ERR_COUNT_WIDTH-1:0] errCount,
    output logic                       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [OPCODE_WIDTH-1:0] OP_DIV  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LAST = OPCODE_WIDTH'(13);

    logic [1:0] state;
    logic       cmdAccept;
    logic       rspAccept;
    logic       cmdIllegal;

    // Handshake qualifiers and command screening
    always_comb begin
        cmdReady   = (state == IDLE);
        rspValid   = (state == RESP);
        busy       = (state != IDLE);
        cmdAccept  = cmdValid && cmdReady;
        rspAccept  = rspValid && rspReady;
        cmdIllegal = (cmdOpCode > OP_LAST) ||
                     (((cmdOpCode == OP_DIV) || (cmdOpCode == OP_MOD)) && (cmdData2 == '0));
    end

    // Sequencer FSM with operand, response and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            aluOpCode     <= '0;
            aluInputData1 <= '0;
            aluInputData2 <= '0;
            rspData       <= '0;
            rspError      <= 1'b0;
            opCount       <= '0;
            errCount      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdAccept) begin
                        if (cmdIllegal) begin
                            rspData  <= '0;
                            rspError <= 1'b1;
                            state    <= RESP;
                        end else begin
                            aluOpCode     <= cmdOpCode;
                            aluInputData1 <= cmdData1;
                            aluInputData2 <= cmdData2;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    rspData  <= aluOutputData;
                    rspError <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    if (rspAccept) begin
                        state <= IDLE;
                        if (rspError) begin
                            if (errCount != '1) begin
                                errCount <= errCount + 1'b1;
                            end
                        end else begin
                            opCount <= opCount + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU model.
// opCount is narrowed to 8 bits so the wrap scenario stays short.
module tb_alu_sequencer;

    localparam int DW = 32;
    localparam int OW = 6;
    localparam int CW = 8;
    localparam int EW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [OW-1:0] cmdOpCode = '0;
    logic [DW-1:0] cmdData1 = '0;
    logic [DW-1:0] cmdData2 = '0;
    logic [OW-1:0] aluOpCode;
    logic [DW-1:0] aluInputData1;
    logic [DW-1:0] aluInputData2;
    logic [DW-1:0] aluOutputData;
    logic          rspValid;
    logic          rspReady = 1'b1;
    logic [DW-1:0] rspData;
    logic          rspError;
    logic [CW-1:0] opCount;
    logic [EW-1:0] errCount;
    logic          busy;

    int checks = 0;
    int passes = 0;

    alu_sequencer #(
        .DATA_WIDTH(DW),
        .OPCODE_WIDTH(OW),
        .OP_COUNT_WIDTH(CW),
        .ERR_COUNT_WIDTH(EW)
    ) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOpCode(cmdOpCode),
        .cmdData1(cmdData1), .cmdData2(cmdData2),
        .aluOpCode(aluOpCode), .aluInputData1(aluInputData1), .aluInputData2(aluInputData2),
        .aluOutputData(aluOutputData),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspError(rspError),
        .opCount(opCount), .errCount(errCount), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural ALU standing in for the external combinational block
    always_comb begin
        aluOutputData = '0;
        case (aluOpCode)
            6'd0:  aluOutputData = aluInputData1 + aluInputData2;
            6'd1:  aluOutputData = aluInputData1 - aluInputData2;
            6'd2:  aluOutputData = aluInputData1 * aluInputData2;
            6'd3:  aluOutputData = (aluInputData2 != 0) ? aluInputData1 / aluInputData2 : '0;
            6'd4:  aluOutputData = (aluInputData2 != 0) ? aluInputData1 % aluInputData2 : '0;
            6'd5:  aluOutputData = aluInputData1 << aluInputData2[4:0];
            6'd6:  aluOutputData = aluInputData1 >> aluInputData2[4:0];
            6'd7:  aluOutputData = aluInputData1 & aluInputData2;
            6'd8:  aluOutputData = aluInputData1 | aluInputData2;
            6'd9:  aluOutputData = ~aluInputData1;
            6'd10: aluOutputData = {31'd0, aluInputData1 == aluInputData2};
            6'd11: aluOutputData = {31'd0, aluInputData1 != aluInputData2};
            6'd12: aluOutputData = {31'd0, $signed(aluInputData1) < $signed(aluInputData2)};
            6'd13: aluOutputData = {31'd0, $signed(aluInputData1) <= $signed(aluInputData2)};
            default: aluOutputData = '0;
        endcase
    end

    // Present a command at a falling edge; returns just after the accept edge
    task automatic sendCmd(input logic [OW-1:0] op, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        int n;
        n = 0;
        @(negedge clock);
        while (!cmdReady && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!cmdReady) begin
            checks++;
            $display("FAIL cmdReady_timeout: cmdReady=%0b required 1", cmdReady);
        end
        cmdValid  = 1'b1;
        cmdOpCode = op;
        cmdData1  = d1;
        cmdData2  = d2;
        @(posedge clock);
        #1;
        cmdValid  = 1'b0;
        cmdData1  = 32'hDEAD_BEEF;
        cmdData2  = 32'h0BAD_F00D;
    endtask

    // Command then bounded wait for rspValid; lat counts falling edges after accept
    task automatic runCmd(input logic [OW-1:0] op, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                          output int lat);
        sendCmd(op, d1, d2);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rspValid && lat < 10);
        if (!rspValid) begin
            checks++;
            $display("FAIL rspValid_timeout: no response within %0d cycles", lat);
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        cmdValid = 1'b1;
        cmdOpCode = 6'd0;
        cmdData1 = 32'd1;
        cmdData2 = 32'd2;
        repeat (3) @(negedge clock);
        checks++;
        if ({cmdReady, rspValid, rspError, busy} !== 4'b1000 || rspData !== 0 || aluOpCode !== 0 ||
            aluInputData1 !== 0 || aluInputData2 !== 0 || opCount !== 0 || errCount !== 0)
            $display("FAIL reset_values: rdy=%0b vld=%0b err=%0b busy=%0b data=%h alu=%0d/%h/%h cnt=%0d/%0d required 1 0 0 0 0 0/0/0 0/0",
                     cmdReady, rspValid, rspError, busy, rspData, aluOpCode, aluInputData1, aluInputData2, opCount, errCount);
        else passes++;
        cmdValid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || aluInputData1 !== 0) $display("FAIL reset_handshake: busy=%0b alu1=%h required 0 0", busy, aluInputData1);
        else passes++;
    endtask

    task automatic test_add;
        int lat;
        runCmd(6'd0, 32'd5, 32'd7, lat);
        checks++;
        if (lat !== 2 || rspData !== 32'd12 || rspError !== 1'b0 || aluOpCode !== 6'd0)
            $display("FAIL add: lat=%0d data=%0d err=%0b op=%0d required 2 12 0 0", lat, rspData, rspError, aluOpCode);
        else passes++;
        @(negedge clock);
        checks++;
        if (opCount !== 1 || rspValid !== 1'b0 || cmdReady !== 1'b1)
            $display("FAIL add_count: opCount=%0d vld=%0b rdy=%0b required 1 0 1", opCount, rspValid, cmdReady);
        else passes++;
    endtask

    task automatic test_lt_sub;
        int lat;
        runCmd(6'd12, 32'hFFFF_FFFF, 32'd1, lat);
        checks++;
        if (rspData !== 32'd1 || rspError !== 1'b0) $display("FAIL lt: data=%h err=%0b required 1 0", rspData, rspError);
        else passes++;
        runCmd(6'd1, 32'd3, 32'd5, lat);
        checks++;
        if (rspData !== 32'hFFFF_FFFE || lat !== 2) $display("FAIL sub: data=%h lat=%0d required fffffffe 2", rspData, lat);
        else passes++;
        @(negedge clock);
        checks++;
        if (opCount !== 3) $display("FAIL sub_count: opCount=%0d required 3", opCount);
        else passes++;
    endtask

    task automatic test_errors;
        int lat;
        runCmd(6'd3, 32'd10, 32'd0, lat);
        checks++;
        if (lat !== 1 || rspData !== 0 || rspError !== 1'b1 || aluOpCode !== 6'd1 ||
            aluInputData1 !== 32'd3 || aluInputData2 !== 32'd5)
            $display("FAIL div_zero: lat=%0d data=%h err=%0b alu=%0d/%h/%h required 1 0 1 1/3/5",
                     lat, rspData, rspError, aluOpCode, aluInputData1, aluInputData2);
        else passes++;
        runCmd(6'd20, 32'd9, 32'd9, lat);
        checks++;
        if (lat !== 1 || rspData !== 0 || rspError !== 1'b1 || aluOpCode !== 6'd1 || aluInputData1 !== 32'd3)
            $display("FAIL bad_opcode: lat=%0d data=%h err=%0b op=%0d alu1=%h required 1 0 1 1 3",
                     lat, rspData, rspError, aluOpCode, aluInputData1);
        else passes++;
        @(negedge clock);
        checks++;
        if (errCount !== 2 || opCount !== 3) $display("FAIL err_counts: errCount=%0d opCount=%0d required 2 3", errCount, opCount);
        else passes++;
        // Modulo with nonzero divisor is legal
        runCmd(6'd4, 32'd17, 32'd5, lat);
        checks++;
        if (lat !== 2 || rspData !== 32'd2 || rspError !== 1'b0) $display("FAIL mod: lat=%0d data=%0d err=%0b required 2 2 0", lat, rspData, rspError);
        else passes++;
        @(negedge clock);
    endtask

    task automatic test_backpressure;
        int lat;
        rspReady = 1'b0;
        runCmd(6'd2, 32'd6, 32'd7, lat);
        cmdValid  = 1'b1;
        cmdOpCode = 6'd0;
        cmdData1  = 32'd100;
        cmdData2  = 32'd200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (rspValid !== 1'b1 || rspData !== 32'd42 || cmdReady !== 1'b0 || rspError !== 1'b0)
                $display("FAIL backpressure_%0d: vld=%0b data=%0d rdy=%0b err=%0b required 1 42 0 0", i, rspValid, rspData, cmdReady, rspError);
            else passes++;
        end
        cmdValid = 1'b0;
        rspReady = 1'b1;
        @(negedge clock);
        checks++;
        if (cmdReady !== 1'b1 || rspValid !== 1'b0 || opCount !== 5 || aluOpCode !== 6'd2 || aluInputData1 !== 32'd6)
            $display("FAIL backpressure_release: rdy=%0b vld=%0b opCount=%0d op=%0d alu1=%0d required 1 0 5 2 6",
                     cmdReady, rspValid, opCount, aluOpCode, aluInputData1);
        else passes++;
    endtask

    task automatic test_reset_in_issue;
        int sawValid;
        sawValid = 0;
        sendCmd(6'd7, 32'hF0F0, 32'hFF00);
        checks++;
        if (busy !== 1'b1 || rspValid !== 1'b0) $display("FAIL issue_state: busy=%0b vld=%0b required 1 0", busy, rspValid);
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cmdReady !== 1'b1 || rspValid !== 1'b0 || aluOpCode !== 0 || aluInputData1 !== 0 ||
            opCount !== 0 || errCount !== 0 || rspData !== 0)
            $display("FAIL reset_abort: busy=%0b rdy=%0b vld=%0b op=%0d alu1=%h cnt=%0d/%0d data=%h required 0 1 0 0 0 0/0 0",
                     busy, cmdReady, rspValid, aluOpCode, aluInputData1, opCount, errCount, rspData);
        else passes++;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (rspValid) sawValid++;
        end
        checks++;
        if (sawValid !== 0 || opCount !== 0 || errCount !== 0 || busy !== 1'b0)
            $display("FAIL reset_after: vldSeen=%0d cnt=%0d/%0d busy=%0b required 0 0/0 0", sawValid, opCount, errCount, busy);
        else passes++;
    endtask

    task automatic test_counters;
        int lat;
        for (int i = 0; i < 257; i++) runCmd(6'd8, i, 32'd1, lat);
        @(negedge clock);
        checks++;
        if (opCount !== 8'd1 || errCount !== 0) $display("FAIL op_wrap: opCount=%0d errCount=%0d required 1 0", opCount, errCount);
        else passes++;
        for (int i = 0; i < 300; i++) runCmd(6'd63, 32'd1, 32'd1, lat);
        @(negedge clock);
        checks++;
        if (errCount !== 8'd255 || opCount !== 8'd1) $display("FAIL err_saturate: errCount=%0d opCount=%0d required 255 1", errCount, opCount);
        else passes++;
    endtask

    initial begin
        test_reset;
        test_add;
        test_lt_sub;
        test_errors;
        test_backpressure;
        test_reset_in_issue;
        test_counters;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
